wb_sram_target: RTL and testbench
=================================

// Module: wb_sram_target
// PURPOSE
//   Wishbone-style single-port SRAM responder: target end of the ram_arb X port.
//   Accepts one cyc/we/sel/adr/dat request at a time, inserts programmable wait
//   states, performs a byte-lane-masked word write or a word read, and returns a
//   single-cycle ack with read data. Sits directly below the RAM arbiter.
// PARAMETERS
//   WIDTH        10   word-address width; memory depth = 2**WIDTH x 32 bits
//   WAIT_STATES  0    extra cycles inserted before ack (0..15)
// PORTS
//   wb_clk    in   1      clock; all state changes on posedge
//   wb_rst    in   1      asynchronous, active-high reset
//   wb_cyc    in   1      request valid; held high by initiator until ack
//   wb_we     in   1      1 = write, 0 = read
//   wb_sel    in   4      byte-lane enables; sel[i] selects dat[8i+7:8i]
//   wb_adr    in   WIDTH  word address
//   wb_dat    in   32     write data
//   wb_ack    out  1      one-cycle completion pulse
//   wb_rdt    out  32     read data; valid only while wb_ack=1 on a read, else 0
//   wb_wp     in   1      write-protect (present only with WB_SRAM_WPROT_EN)
// BEHAVIOUR
//   - Reset (async, any time): state=IDLE, wait counter=0, wb_ack=0, wb_rdt=0.
//     Memory contents not reset. An access not yet committed when wb_rst rises
//     is dropped: no write, no ack.
//   - FSM states: IDLE, WAIT, ACK, TURN. wb_ack and wb_rdt are registered.
//     IDLE: cyc=1 -> ACK if WAIT_STATES=0 (access performed on this edge);
//           otherwise -> WAIT, cnt <= WAIT_STATES-1.
//     WAIT: cyc=0 -> IDLE (abort: no write, no ack);
//           cnt=0 -> ACK (access performed on this edge); else cnt <= cnt-1.
//     ACK:  wb_ack=1 for exactly this cycle -> TURN unconditionally.
//     TURN: wb_ack=0; cyc ignored -> IDLE.
//   - Access edge: the edge entering ACK. adr/we/sel/dat are sampled there.
//     Write: mem[adr] byte i <= dat byte i for each sel[i]=1. sel=0 still acks.
//     Read: wb_rdt <= mem[adr] (full word, sel ignored).
//     Leaving ACK clears wb_rdt to 0.
//   - Latency: cyc first high in cycle k -> wb_ack high in cycle k+1+WAIT_STATES.
//     Back-to-back throughput: one access per WAIT_STATES+3 cycles.
//   - cyc held high through TURN does not re-trigger; it is resampled in IDLE.
//   - cyc dropping during ACK does not undo a write already committed.
//   - Read after write to the same address in the next transaction returns
//     the new data.
//   - Full address range valid; no decode or error response.
// CONFIGURATION
//   WB_SRAM_WPROT_EN defined: adds input wb_wp. A write whose access edge sees
//     wb_wp=1 is acked normally but memory is unchanged. Reads are unaffected.
//   Not defined: port absent; all writes commit.
// TESTING
//   1. WAIT_STATES=0: write adr=5, dat=32'hDEADBEEF, sel=4'hF; then read adr=5
//      -> ack 1 cycle after cyc, rdt=32'hDEADBEEF during ack, 0 otherwise.
//   2. Byte lanes: mem[7]=32'h11223344; write sel=4'b0101, dat=32'hAABBCCDD;
//      read adr=7 -> 32'h11BB33DD.
//   3. WAIT_STATES=3: read -> ack in cycle k+4; drop cyc in cycle k+2 on a
//      write -> no ack, memory unchanged, FSM back in IDLE.
//   4. Hold cyc high across two transactions -> acks exactly
//      WAIT_STATES+3 cycles apart; ack is never 2 cycles wide.
//   5. Assert wb_rst in WAIT during a write to adr=9 -> ack=0 and rdt=0
//      immediately; mem[9] unchanged.
//   6. WB_SRAM_WPROT_EN, wb_wp=1: write 32'h0 to adr=5 holding 32'hDEADBEEF
//      -> ack given; subsequent read returns 32'hDEADBEEF.

Source files
------------

// File: rtl/wb_sram_target.sv
// Wishbone-style single-port SRAM target with programmable wait states.
// Accepts one request at a time. It performs a byte-lane-masked word write or a
// full-word read on the edge that enters ACK. It then returns a one-cycle ack,
// followed by a one-cycle turnaround.
// Optional feature macro: WB_SRAM_WPROT_EN adds the wb_wp write-protect input.
// Ports:
//   wb_clk, wb_rst        clock, asynchronous active-high reset
//   wb_cyc, wb_we         request valid (held until ack), write select
//   wb_sel[3:0]           byte-lane enables for writes
//   wb_adr[WIDTH-1:0]     word address
//   wb_dat[31:0]          write data
//   wb_wp                 write protect (only with WB_SRAM_WPROT_EN)
//   wb_ack                registered one-cycle completion pulse
//   wb_rdt[31:0]          registered read data, non-zero only during a read ack
module wb_sram_target #(
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             wb_cyc,
    input  logic             wb_we,
    input  logic [3:0]       wb_sel,
    input  logic [WIDTH-1:0] wb_adr,
    input  logic [31:0]      wb_dat,
`ifdef WB_SRAM_WPROT_EN
    input  logic             wb_wp,
`endif
    output logic             wb_ack,
    output logic [31:0]      wb_rdt
);

    localparam int unsigned DEPTH = 1 << WIDTH;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_TURN
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        mem [DEPTH];

    logic               wp_c;
    logic               access_c;
    logic               write_c;

`ifdef WB_SRAM_WPROT_EN
    assign wp_c = wb_wp;
`else
    assign wp_c = 1'b0;
`endif

    // Access edge: the edge that moves the FSM into ACK. Gated by reset so that
    // a request in flight when reset rises never commits.
    assign access_c = !wb_rst && wb_cyc &&
                      (((state == S_IDLE) && (WAIT_STATES == 0)) ||
                       ((state == S_WAIT) && (cnt == '0)));
    assign write_c  = access_c && wb_we && !wp_c;

    // Control FSM with registered ack and read data.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            wb_ack <= 1'b0;
            wb_rdt <= '0;
        end else begin
            wb_ack <= 1'b0;
            wb_rdt <= '0;
            case (state)
                S_IDLE: begin
                    if (access_c) begin
                        state  <= S_ACK;
                        wb_ack <= 1'b1;
                        if (!wb_we) wb_rdt <= mem[wb_adr];
                    end else if (wb_cyc) begin
                        state <= S_WAIT;
                        cnt   <= CNT_W'(WAIT_STATES - 1);
                    end
                end
                S_WAIT: begin
                    if (!wb_cyc) begin
                        state <= S_IDLE;
                    end else if (access_c) begin
                        state  <= S_ACK;
                        wb_ack <= 1'b1;
                        if (!wb_we) wb_rdt <= mem[wb_adr];
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ACK:   state <= S_TURN;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge wb_clk) begin
        if (write_c) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_sel[i]) mem[wb_adr][8*i +: 8] <= wb_dat[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_target.sv
// Directed self-checking bench for wb_sram_target. It drives two instances that
// share the clock, reset and request fields: one with WAIT_STATES=0 (u0) and one
// with WAIT_STATES=3 (u3). Each instance has its own cyc, ack and rdt.
module tb_wb_sram_target;

    logic        clk;
    logic        rst;
    logic        cyc0, cyc3;
    logic        we;
    logic [3:0]  sel;
    logic [9:0]  adr;
    logic [31:0] dat;
    logic        wp;
    logic        ack0, ack3;
    logic [31:0] rdt0, rdt3;

    int tests;
    int fails;

    wb_sram_target #(.WIDTH(10), .WAIT_STATES(0)) u0 (
        .wb_clk(clk), .wb_rst(rst), .wb_cyc(cyc0), .wb_we(we), .wb_sel(sel),
        .wb_adr(adr), .wb_dat(dat),
`ifdef WB_SRAM_WPROT_EN
        .wb_wp(wp),
`endif
        .wb_ack(ack0), .wb_rdt(rdt0)
    );

    wb_sram_target #(.WIDTH(10), .WAIT_STATES(3)) u3 (
        .wb_clk(clk), .wb_rst(rst), .wb_cyc(cyc3), .wb_we(we), .wb_sel(sel),
        .wb_adr(adr), .wb_dat(dat),
`ifdef WB_SRAM_WPROT_EN
        .wb_wp(wp),
`endif
        .wb_ack(ack3), .wb_rdt(rdt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction on instance 'which' (0 or 3). lat counts the cycles from
    // the cycle in which cyc is first high to the cycle in which ack is high.
    // lat is -1 on timeout.
    task automatic xfer(input int which, input logic w, input logic [3:0] s,
                        input logic [9:0] a, input logic [31:0] d,
                        output logic [31:0] r, output int lat);
        logic ak;
        @(posedge clk); #1;
        we = w; sel = s; adr = a; dat = d;
        if (which == 0) cyc0 = 1'b1; else cyc3 = 1'b1;
        lat = -1;
        r   = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            ak = (which == 0) ? ack0 : ack3;
            if (ak) begin
                lat = n;
                r   = (which == 0) ? rdt0 : rdt3;
                break;
            end
        end
        @(posedge clk); #1;
        cyc0 = 1'b0; cyc3 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (ack0 !== 1'b0) begin fails++; $display("FAIL reset_ack0 got %b exp 0", ack0); end
        tests++; if (rdt0 !== 32'h0) begin fails++; $display("FAIL reset_rdt0 got %h exp 0", rdt0); end
        tests++; if (ack3 !== 1'b0) begin fails++; $display("FAIL reset_ack3 got %b exp 0", ack3); end
        tests++; if (rdt3 !== 32'h0) begin fails++; $display("FAIL reset_rdt3 got %h exp 0", rdt3); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [31:0] r;
        int lat;
        xfer(0, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF, r, lat);
        tests++; if (lat !== 1) begin fails++; $display("FAIL ws0_write_lat got %0d exp 1", lat); end
        xfer(0, 1'b0, 4'hF, 10'd5, 32'h0, r, lat);
        tests++; if (lat !== 1) begin fails++; $display("FAIL ws0_read_lat got %0d exp 1", lat); end
        tests++; if (r !== 32'hDEADBEEF) begin fails++; $display("FAIL ws0_read_data got %h exp deadbeef", r); end
        // The FSM is in TURN after xfer returns; rdt must already be cleared.
        @(negedge clk);
        tests++; if (rdt0 !== 32'h0) begin fails++; $display("FAIL ws0_rdt_after_ack got %h exp 0", rdt0); end
        tests++; if (ack0 !== 1'b0) begin fails++; $display("FAIL ws0_ack_after got %b exp 0", ack0); end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] r;
        int lat;
        xfer(0, 1'b1, 4'hF, 10'd7, 32'h11223344, r, lat);
        xfer(0, 1'b1, 4'b0101, 10'd7, 32'hAABBCCDD, r, lat);
        xfer(0, 1'b0, 4'h0, 10'd7, 32'h0, r, lat);
        tests++; if (r !== 32'h11BB33DD) begin fails++; $display("FAIL lanes_0101 got %h exp 11bb33dd", r); end
        xfer(0, 1'b1, 4'h0, 10'd7, 32'hFFFFFFFF, r, lat);
        tests++; if (lat !== 1) begin fails++; $display("FAIL lanes_sel0_ack got lat %0d exp 1", lat); end
        xfer(0, 1'b0, 4'hF, 10'd7, 32'h0, r, lat);
        tests++; if (r !== 32'h11BB33DD) begin fails++; $display("FAIL lanes_sel0_data got %h exp 11bb33dd", r); end
        xfer(0, 1'b1, 4'b1000, 10'd7, 32'h99000000, r, lat);
        xfer(0, 1'b0, 4'hF, 10'd7, 32'h0, r, lat);
        tests++; if (r !== 32'h99BB33DD) begin fails++; $display("FAIL lanes_1000 got %h exp 99bb33dd", r); end
    endtask

    task automatic test_wait_states;
        logic [31:0] r;
        int lat;
        int seen;
        xfer(3, 1'b1, 4'hF, 10'd20, 32'hCAFEF00D, r, lat);
        tests++; if (lat !== 4) begin fails++; $display("FAIL ws3_write_lat got %0d exp 4", lat); end
        xfer(3, 1'b0, 4'hF, 10'd20, 32'h0, r, lat);
        tests++; if (lat !== 4) begin fails++; $display("FAIL ws3_read_lat got %0d exp 4", lat); end
        tests++; if (r !== 32'hCAFEF00D) begin fails++; $display("FAIL ws3_read_data got %h exp cafef00d", r); end
        // Abort: cyc is high in cycle k and k+1, then low from cycle k+2.
        @(posedge clk); #1;
        we = 1'b1; sel = 4'hF; adr = 10'd20; dat = 32'h0; cyc3 = 1'b1;
        seen = 0;
        @(negedge clk); if (ack3) seen++;
        @(negedge clk); if (ack3) seen++;
        @(posedge clk); #1;
        cyc3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); if (ack3) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL abort_no_ack got %0d acks exp 0", seen); end
        xfer(3, 1'b0, 4'hF, 10'd20, 32'h0, r, lat);
        tests++; if (r !== 32'hCAFEF00D) begin fails++; $display("FAIL abort_mem got %h exp cafef00d", r); end
        tests++; if (lat !== 4) begin fails++; $display("FAIL abort_idle_lat got %0d exp 4", lat); end
    endtask

    // Hold cyc high across several transactions and measure the ack spacing.
    task automatic test_back_to_back(input int which, input int gap_exp);
        int first, second, wide, stray;
        logic prev, ak;
        logic [31:0] rd;
        first = -1; second = -1; wide = 0; stray = 0; prev = 1'b0;
        @(posedge clk); #1;
        we = 1'b0; sel = 4'hF; adr = (which == 0) ? 10'd5 : 10'd20;
        if (which == 0) cyc0 = 1'b1; else cyc3 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ak = (which == 0) ? ack0 : ack3;
            rd = (which == 0) ? rdt0 : rdt3;
            if (ak && prev) wide++;
            if (!ak && rd !== 32'h0) stray++;
            if (ak && !prev) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            prev = ak;
        end
        @(posedge clk); #1;
        cyc0 = 1'b0; cyc3 = 1'b0;
        repeat (8) @(posedge clk);
        tests++; if ((second - first) !== gap_exp || first < 0)
            begin fails++; $display("FAIL b2b_gap_ws%0d got %0d exp %0d", which, second - first, gap_exp); end
        tests++; if (wide !== 0) begin fails++; $display("FAIL b2b_wide_ws%0d got %0d exp 0", which, wide); end
        tests++; if (stray !== 0) begin fails++; $display("FAIL b2b_rdt_idle_ws%0d got %0d exp 0", which, stray); end
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] r;
        int lat;
        xfer(3, 1'b1, 4'hF, 10'd9, 32'h12345678, r, lat);
        // Start a write to 9 and reset two cycles later while still in WAIT.
        @(posedge clk); #1;
        we = 1'b1; sel = 4'hF; adr = 10'd9; dat = 32'h0; cyc3 = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++; if (ack3 !== 1'b0) begin fails++; $display("FAIL rstwait_ack got %b exp 0", ack3); end
        tests++; if (rdt3 !== 32'h0) begin fails++; $display("FAIL rstwait_rdt got %h exp 0", rdt3); end
        repeat (3) @(posedge clk);
        #1;
        cyc3 = 1'b0; rst = 1'b0;
        xfer(3, 1'b0, 4'hF, 10'd9, 32'h0, r, lat);
        tests++; if (r !== 32'h12345678) begin fails++; $display("FAIL rstwait_mem got %h exp 12345678", r); end
        // Reset during a read ack must clear ack and rdt without waiting for a clock.
        @(posedge clk); #1;
        we = 1'b0; sel = 4'hF; adr = 10'd5; cyc0 = 1'b1;
        @(posedge clk); #1;
        tests++; if (ack0 !== 1'b1 || rdt0 !== 32'hDEADBEEF)
            begin fails++; $display("FAIL rstack_pre got ack %b rdt %h exp 1 deadbeef", ack0, rdt0); end
        rst = 1'b1;
        #1;
        tests++; if (ack0 !== 1'b0 || rdt0 !== 32'h0)
            begin fails++; $display("FAIL rstack_async got ack %b rdt %h exp 0 0", ack0, rdt0); end
        cyc0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

`ifdef WB_SRAM_WPROT_EN
    task automatic test_write_protect;
        logic [31:0] r;
        int lat;
        wp = 1'b1;
        xfer(0, 1'b1, 4'hF, 10'd5, 32'h0, r, lat);
        tests++; if (lat !== 1) begin fails++; $display("FAIL wp_ack got lat %0d exp 1", lat); end
        xfer(0, 1'b0, 4'hF, 10'd5, 32'h0, r, lat);
        tests++; if (r !== 32'hDEADBEEF) begin fails++; $display("FAIL wp_mem got %h exp deadbeef", r); end
        wp = 1'b0;
    endtask
`endif

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; cyc0 = 1'b0; cyc3 = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; dat = '0; wp = 1'b0;
        test_reset();
        test_basic();
        test_byte_lanes();
        test_wait_states();
        test_back_to_back(0, 3);
        test_back_to_back(3, 6);
        test_reset_in_wait();
`ifdef WB_SRAM_WPROT_EN
        test_write_protect();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
